// File: rtl/demux_tdm.sv
// demux_tdm: 4-slot time-division demultiplexer with atomic frame update,
// resync error detection and a wrapping count of complete frames.
module demux_tdm #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] D,
    input  logic             valid,
    input  logic             sync,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic [1:0]       S,
    output logic             quadro_ok,
    output logic             erro_quadro,
    output logic [7:0]       quadros
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RECV = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       s_q, s_d;
    logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [WIDTH-1:0] y0_q, y0_d, y1_q, y1_d, y2_q, y2_d, y3_q, y3_d;
    logic             ok_q, ok_d, err_q, err_d;
    logic [7:0]       cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        sh0_d   = sh0_q;
        sh1_d   = sh1_q;
        sh2_d   = sh2_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        y2_d    = y2_q;
        y3_d    = y3_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        if (valid) begin
            if (sync) begin
                // a sync while receiving throws away the partial frame
                err_d   = (state_q == RECV);
                sh0_d   = D;
                s_d     = 2'd1;
                state_d = RECV;
            end else if (state_q == RECV) begin
                sh1_d = (s_q == 2'd1) ? D : sh1_q;
                sh2_d = (s_q == 2'd2) ? D : sh2_q;
                s_d   = s_q + 2'd1;
                if (s_q == 2'd3) begin
                    y0_d    = sh0_q;
                    y1_d    = sh1_q;
                    y2_d    = sh2_q;
                    y3_d    = D;
                    ok_d    = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    state_d = IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            sh0_q   <= '0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            y2_q    <= '0;
            y3_q    <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            sh0_q   <= sh0_d;
            sh1_q   <= sh1_d;
            sh2_q   <= sh2_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            y2_q    <= y2_d;
            y3_q    <= y3_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign Y0          = y0_q;
    assign Y1          = y1_q;
    assign Y2          = y2_q;
    assign Y3          = y3_q;
    assign S           = s_q;
    assign quadro_ok   = ok_q;
    assign erro_quadro = err_q;
    assign quadros     = cnt_q;
endmodule

// File: tb/tb_demux_tdm.sv
// tb_demux_tdm: randomized and directed stimulus for demux_tdm; a frame-level
// model queues expected pulse events that an independent monitor checks.
module tb_demux_tdm;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] D = '0;
    logic       valid = 1'b0;
    logic       sync = 1'b0;
    logic [3:0] Y0, Y1, Y2, Y3;
    logic [1:0] S;
    logic       quadro_ok, erro_quadro;
    logic [7:0] quadros;

    demux_tdm #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .D(D), .valid(valid), .sync(sync),
        .Y0(Y0), .Y1(Y1), .Y2(Y2), .Y3(Y3), .S(S),
        .quadro_ok(quadro_ok), .erro_quadro(erro_quadro), .quadros(quadros)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       ok;
        logic [3:0] y0, y1, y2, y3;
        logic [7:0] cnt;
    } ev_t;

    ev_t        exp_q[$];
    logic [3:0] slots[$];
    logic [3:0] last_y[4];
    logic [7:0] model_cnt;
    int         exp_s;
    int         n_checks = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    function automatic void check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic void model_reset();
        slots.delete();
        exp_q.delete();
        for (int i = 0; i < 4; i++) last_y[i] = '0;
        model_cnt = '0;
        exp_s = 0;
    endfunction

    // frame-level reference: a frame is a sync beat followed by three plain beats
    task automatic beat(input bit v, input bit s, input logic [3:0] d);
        @(negedge clk);
        #1;
        valid = v;
        sync  = s;
        D     = d;
        if (v) begin
            if (s) begin
                if (slots.size() > 0)
                    exp_q.push_back('{1'b0, last_y[0], last_y[1], last_y[2], last_y[3], model_cnt});
                slots.delete();
                slots.push_back(d);
            end else if (slots.size() > 0) begin
                slots.push_back(d);
                if (slots.size() == 4) begin
                    for (int i = 0; i < 4; i++) last_y[i] = slots[i];
                    model_cnt = model_cnt + 8'd1;
                    exp_q.push_back('{1'b1, last_y[0], last_y[1], last_y[2], last_y[3], model_cnt});
                    slots.delete();
                end
            end
        end
        exp_s = slots.size();
    endtask

    task automatic frame(input logic [3:0] a, b, c, e);
        beat(1, 1, a);
        beat(1, 0, b);
        beat(1, 0, c);
        beat(1, 0, e);
    endtask

    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            check("S", int'(S), exp_s);
            check("pulse_excl", int'(quadro_ok & erro_quadro), 0);
            if (quadro_ok || erro_quadro) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", int'({quadro_ok, erro_quadro}), 0);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("pulse_kind", int'(quadro_ok), int'(e.ok));
                    check("Y", int'({Y0, Y1, Y2, Y3}), int'({e.y0, e.y1, e.y2, e.y3}));
                    check("quadros", int'(quadros), int'(e.cnt));
                end
            end
        end
    end

    initial begin
        int ok_seen;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_Y", int'({Y0, Y1, Y2, Y3}), 0);
        check("rst_S", int'(S), 0);
        check("rst_cnt", int'(quadros), 0);
        check("rst_pulses", int'({quadro_ok, erro_quadro}), 0);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;

        frame(4'h1, 4'h2, 4'h3, 4'h4);
        beat(0, 0, 0);
        check("basic_Y", int'({Y0, Y1, Y2, Y3}), 16'h1234);
        check("basic_cnt", int'(quadros), 1);

        beat(1, 1, 4'h1);
        beat(1, 0, 4'h2);
        repeat (3) beat(0, 0, 4'hF);
        beat(1, 0, 4'h3);
        beat(1, 0, 4'h4);
        beat(0, 0, 0);
        check("gap_cnt", int'(quadros), 2);

        beat(1, 1, 4'hA);
        beat(1, 0, 4'hB);
        frame(4'h5, 4'h6, 4'h7, 4'h8);
        beat(0, 0, 0);
        check("resync_Y", int'({Y0, Y1, Y2, Y3}), 16'h5678);
        check("resync_cnt", int'(quadros), 3);

        repeat (3) beat(1, 0, 4'h9);
        frame(4'h9, 4'hA, 4'hB, 4'hC);
        ok_seen = 0;
        frame(4'hD, 4'hE, 4'hF, 4'h0);
        beat(0, 0, 0);
        check("b2b_Y", int'({Y0, Y1, Y2, Y3}), 16'hDEF0);
        check("b2b_cnt", int'(quadros), 5);

        for (int i = 0; i < 2000; i++)
            beat($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)));

        while (slots.size() != 0) beat(1, 0, 4'($urandom_range(0, 15)));
        while (model_cnt != 8'd0) frame(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
        beat(0, 0, 0);
        check("wrap_cnt", int'(quadros), 0);

        frame(4'h1, 4'h2, 4'h3, 4'h4);
        beat(1, 1, 4'h7);
        beat(1, 0, 4'h8);
        beat(0, 0, 0);
        @(negedge clk);
        check("pre_rst_S", int'(S), 2);
        check("pre_rst_Y", int'({Y0, Y1, Y2, Y3}), 16'h1234);
        mon_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_Y", int'({Y0, Y1, Y2, Y3}), 0);
        check("async_S", int'(S), 0);
        check("async_cnt", int'(quadros), 0);
        check("async_pulses", int'({quadro_ok, erro_quadro}), 0);
        check("queue_drained", exp_q.size(), 0);
        model_reset();
        @(negedge clk);
        #1 rst_n = 1'b1;
        mon_en = 1'b1;
        beat(1, 0, 4'h3);
        frame(4'hC, 4'hA, 4'hF, 4'hE);
        beat(0, 0, 0);
        beat(0, 0, 0);
        check("post_rst_Y", int'({Y0, Y1, Y2, Y3}), 16'hCAFE);
        check("post_rst_cnt", int'(quadros), 1);
        check("events_left", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
